// File: rtl/shift_engine_pkg.sv
// Shared definitions for the shift/rotate engine.
//   op_e              : operation encoding as presented on the op port
//   state_e           : engine control states
//   WORD_SIZE_DEFAULT : default operand width
package shift_engine_pkg;

  localparam int WORD_SIZE_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_SHR = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
// Ports:
//   op_i : operation to apply
//   r_i  : current working value
//   v_i  : overflow accumulated so far
//   r_o  : value after one step
//   c_o  : bit shifted out (shifts) or wrapped around (rotates)
//   v_o  : updated sticky overflow (only SHL can set it)
module shift_step
  import shift_engine_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
  input  op_e                  op_i,
  input  logic [WORD_SIZE-1:0] r_i,
  input  logic                 v_i,
  output logic [WORD_SIZE-1:0] r_o,
  output logic                 c_o,
  output logic                 v_o
);

  logic msb;
  logic lsb;

  assign msb = r_i[WORD_SIZE-1];
  assign lsb = r_i[0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    r_o = r_i;
    c_o = 1'b0;
    v_o = v_i;
    case (op_i)
      OP_SHL: begin
        c_o = msb;
        // Sign bit changes on this step when the two top bits differ.
        v_o = v_i | (msb ^ r_i[WORD_SIZE-2]);
        r_o = {r_i[WORD_SIZE-2:0], 1'b0};
      end
      OP_SHR: begin
        c_o = lsb;
        r_o = {1'b0, r_i[WORD_SIZE-1:1]};
      end
      OP_ROL: begin
        c_o = msb;
        r_o = {r_i[WORD_SIZE-2:0], msb};
      end
      OP_ROR: begin
        c_o = lsb;
        r_o = {lsb, r_i[WORD_SIZE-1:1]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_rotate_engine.sv
// Multi-bit shift/rotate executor with valid/ready request and result ports.
// Default build shifts one bit per clock; defining SHIFT_ENGINE_FAST_EN
// replaces the serial loop with a barrel shifter so results are ready right
// after acceptance.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start_valid/ready   : request handshake (ready only in IDLE, out of reset)
//   op, amount          : operation and bit count (saturates at WORD_SIZE)
//   reg_in, carry_in    : operand and carry passed through for amount==0
//   res_valid/ready     : result handshake (valid while in DONE)
//   reg_out             : result value
//   zero/carry/overflow : flags for the flag register
//   busy                : engine not in IDLE
module shift_rotate_engine
  import shift_engine_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int AMT_W     = $clog2(WORD_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [1:0]           op,
  input  logic [AMT_W-1:0]     amount,
  input  logic [WORD_SIZE-1:0] reg_in,
  input  logic                 carry_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WORD_SIZE-1:0] reg_out,
  output logic                 zero_flag_out,
  output logic                 carry_flag_out,
  output logic                 overflow_flag_out,
  output logic                 busy
);

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WORD_SIZE);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  state_e               state_q;
  logic [WORD_SIZE-1:0] r_q;
  logic                 c_q;
  logic                 v_q;
  logic [AMT_W-1:0]     amt_sat;

  assign amt_sat = (amount > AMT_MAX) ? AMT_MAX : amount;

`ifdef SHIFT_ENGINE_FAST_EN
  // Closed-form barrel path evaluated on the request inputs.
  logic [WORD_SIZE-1:0]   fast_r;
  logic                   fast_c;
  logic                   fast_v;
  logic [2*WORD_SIZE-1:0] rot_l;
  logic [2*WORD_SIZE-1:0] rot_r;
  logic [WORD_SIZE:0]     shl_ext;
  logic [WORD_SIZE:0]     shr_ext;
  logic [WORD_SIZE:0]     ov_mask;
  logic [WORD_SIZE:0]     ov_bits;

  always_comb begin
    rot_l   = {reg_in, reg_in} << amt_sat;
    rot_r   = {reg_in, reg_in} >> amt_sat;
    // Extra bit catches the last bit out: reg_in[W-k] (SHL), reg_in[k-1] (SHR).
    shl_ext = {1'b0, reg_in} << amt_sat;
    shr_ext = {reg_in, 1'b0} >> amt_sat;
    // Overflow window is the top k+1 bits, with a zero appended below bit 0
    // so that k==WORD_SIZE matches the serial path (last step shifts in 0).
    ov_mask = ~({(WORD_SIZE + 1){1'b1}} >> (amt_sat + AMT_ONE));
    ov_bits = {reg_in, 1'b0} & ov_mask;
    fast_r  = reg_in;
    fast_c  = carry_in;
    fast_v  = 1'b0;
    if (amt_sat != '0) begin
      case (op_e'(op))
        OP_SHL: begin
          fast_r = reg_in << amt_sat;
          fast_c = shl_ext[WORD_SIZE];
          fast_v = (ov_bits != '0) && (ov_bits != ov_mask);
        end
        OP_SHR: begin
          fast_r = reg_in >> amt_sat;
          fast_c = shr_ext[0];
        end
        OP_ROL: begin
          fast_r = rot_l[2*WORD_SIZE-1:WORD_SIZE];
          fast_c = rot_l[WORD_SIZE];
        end
        OP_ROR: begin
          fast_r = rot_r[WORD_SIZE-1:0];
          fast_c = rot_r[WORD_SIZE-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_valid) begin
          r_q     <= fast_r;
          c_q     <= fast_c;
          v_q     <= fast_v;
          state_q <= S_DONE;
        end
        S_DONE: if (res_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  op_e                  op_q;
  logic [AMT_W-1:0]     cnt_q;
  logic [WORD_SIZE-1:0] step_r;
  logic                 step_c;
  logic                 step_v;

  shift_step #(.WORD_SIZE(WORD_SIZE)) u_step (
    .op_i (op_q),
    .r_i  (r_q),
    .v_i  (v_q),
    .r_o  (step_r),
    .c_o  (step_c),
    .v_o  (step_v)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_SHL;
      cnt_q   <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update in
      // this block sees the pre-edge values.
      case (state_q)
        S_IDLE: if (start_valid) begin
          op_q    <= op_e'(op);
          r_q     <= reg_in;
          c_q     <= carry_in;
          v_q     <= 1'b0;
          cnt_q   <= amt_sat;
          state_q <= (amt_sat == '0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          r_q   <= step_r;
          c_q   <= step_c;
          v_q   <= step_v;
          cnt_q <= cnt_q - AMT_ONE;
          if (cnt_q == AMT_ONE) state_q <= S_DONE;
        end
        S_DONE: if (res_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
`endif

  // Gated by reset so no request can be offered while reset is held.
  assign start_ready       = reset && (state_q == S_IDLE);
  assign res_valid         = (state_q == S_DONE);
  assign busy              = (state_q != S_IDLE);
  assign reg_out           = r_q;
  assign carry_flag_out    = c_q;
  assign overflow_flag_out = v_q;
  assign zero_flag_out     = res_valid && (r_q == '0);

endmodule

// File: tb/tb_shift_rotate_engine.sv
// Self-checking bench for shift_rotate_engine (serial or SHIFT_ENGINE_FAST_EN).
module tb_shift_rotate_engine;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic          carry_in = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] amount = '0;
  logic [W-1:0]  reg_in = '0;
  logic          start_ready, res_valid, zero_flag_out, carry_flag_out;
  logic          overflow_flag_out, busy;
  logic [W-1:0]  reg_out;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    int           lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  shift_rotate_engine #(.WORD_SIZE(W), .AMT_W(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .start_valid       (start_valid),
    .start_ready       (start_ready),
    .op                (op),
    .amount            (amount),
    .reg_in            (reg_in),
    .carry_in          (carry_in),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .reg_out           (reg_out),
    .zero_flag_out     (zero_flag_out),
    .carry_flag_out    (carry_flag_out),
    .overflow_flag_out (overflow_flag_out),
    .busy              (busy)
  );

  function automatic int exp_lat(input logic [AW-1:0] a);
`ifdef SHIFT_ENGINE_FAST_EN
    return 0;
`else
    return (a > W) ? W : int'(a);
`endif
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic v,
                              input logic [AW-1:0] a);
    exp_t e;
    e.r = r; e.c = c; e.v = v; e.z = (r == '0); e.lat = exp_lat(a);
    return e;
  endfunction

  // Reference: apply the one-bit step definitions k times.
  function automatic exp_t model(input logic [1:0] o, input logic [AW-1:0] a,
                                 input logic [W-1:0] rin, input logic cin);
    logic [W-1:0] r;
    logic c, v;
    int k;
    k = (a > W) ? W : int'(a);
    r = rin; c = cin; v = 1'b0;
    for (int i = 0; i < k; i++) begin
      case (o)
        2'b00: begin c = r[W-1]; v = v | (r[W-1] ^ r[W-2]); r = {r[W-2:0], 1'b0}; end
        2'b01: begin c = r[0]; r = {1'b0, r[W-1:1]}; end
        2'b10: begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end
        default: begin c = r[0]; r = {r[0], r[W-1:1]}; end
      endcase
    end
    return mk(r, c, v, a);
  endfunction

  task automatic issue(input string name, input logic [1:0] o, input logic [AW-1:0] a,
                       input logic [W-1:0] rin, input logic cin, input exp_t e, input bit push);
    @(negedge clk);
    tests_run++;
    if (start_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s start_ready: got %b want 1", name, start_ready);
    end
    if (push) sb.push_back(e);
    start_valid = 1'b1; op = o; amount = a; reg_in = rin; carry_in = cin;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // Called #1 after the acceptance edge; counts edges until res_valid.
  task automatic wait_result(input string name);
    exp_t e;
    int lat;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    tests_run++;
    if (res_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s timeout: res_valid never rose within 40 edges", name);
    end else begin
      if (lat != e.lat) begin
        tests_failed++;
        $display("FAIL %s latency: got %0d edges want %0d", name, lat, e.lat);
      end
      tests_run++;
      if ({reg_out, carry_flag_out, overflow_flag_out, zero_flag_out} !== {e.r, e.c, e.v, e.z}) begin
        tests_failed++;
        $display("FAIL %s result: got r=%h C=%b V=%b Z=%b want r=%h C=%b V=%b Z=%b", name,
                 reg_out, carry_flag_out, overflow_flag_out, zero_flag_out, e.r, e.c, e.v, e.z);
      end
    end
  endtask

  task automatic release_res(input string name);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    tests_run++;
    if ({start_ready, busy, res_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL %s release: got ready/busy/valid=%b%b%b want 100", name,
               start_ready, busy, res_valid);
    end
  endtask

  task automatic run_req(input string name, input logic [1:0] o, input logic [AW-1:0] a,
                         input logic [W-1:0] rin, input logic cin, input exp_t e);
    issue(name, o, a, rin, cin, e, 1'b1);
    wait_result(name);
    release_res(name);
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if ({start_ready, res_valid, busy, reg_out, carry_flag_out, overflow_flag_out,
         zero_flag_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_held: got ready=%b valid=%b busy=%b r=%h C=%b V=%b Z=%b want all 0",
               start_ready, res_valid, busy, reg_out, carry_flag_out, overflow_flag_out,
               zero_flag_out);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({start_ready, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_release: got ready=%b busy=%b want 1 0", start_ready, busy);
    end
  endtask

  task automatic test_shl();
    run_req("shl_1", 2'b00, 4'd1, 8'b11001100, 1'b0, mk(8'b10011000, 1'b1, 1'b0, 4'd1));
  endtask

  task automatic test_ror();
    run_req("ror_3", 2'b11, 4'd3, 8'b11001100, 1'b0, mk(8'b10011001, 1'b1, 1'b0, 4'd3));
  endtask

  task automatic test_shr_sat();
    run_req("shr_9", 2'b01, 4'd9, 8'b10000000, 1'b0, mk(8'h00, 1'b1, 1'b0, 4'd9));
    run_req("shr_0", 2'b01, 4'd0, 8'b10000000, 1'b1, mk(8'b10000000, 1'b1, 1'b0, 4'd0));
  endtask

  task automatic test_shl_overflow();
    run_req("shl_ovf", 2'b00, 4'd2, 8'b01000000, 1'b0, mk(8'h00, 1'b1, 1'b1, 4'd2));
  endtask

  task automatic test_rotate_sat();
    run_req("rol_12", 2'b10, 4'd12, 8'h5A, 1'b1, mk(8'h5A, 1'b0, 1'b0, 4'd12));
    run_req("ror_8", 2'b11, 4'd8, 8'hA5, 1'b0, mk(8'hA5, 1'b1, 1'b0, 4'd8));
    run_req("shl_15", 2'b00, 4'd15, 8'h81, 1'b0, mk(8'h00, 1'b1, 1'b1, 4'd15));
  endtask

  task automatic test_handshake();
    issue("hold", 2'b10, 4'd2, 8'h81, 1'b0, mk(8'h06, 1'b0, 1'b0, 4'd2), 1'b1);
    wait_result("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_valid = 1'b1; op = 2'b00; amount = 4'd1; reg_in = 8'hFF; carry_in = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if ({res_valid, start_ready, reg_out, carry_flag_out, overflow_flag_out, zero_flag_out}
          !== {1'b1, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: got valid=%b ready=%b r=%h C=%b V=%b Z=%b want 1 0 06 0 0 0",
                 i, res_valid, start_ready, reg_out, carry_flag_out, overflow_flag_out,
                 zero_flag_out);
      end
    end
    @(negedge clk);
    start_valid = 1'b0;
    release_res("hold");
    @(posedge clk); #1;
    tests_run++;
    if ({res_valid, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL hold_no_queue: got valid=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t dummy;
    dummy = mk(8'h00, 1'b0, 1'b0, 4'd8);
    issue("mid_reset", 2'b00, 4'd8, 8'hFF, 1'b0, dummy, 1'b0);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_busy: got %b want 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({start_ready, res_valid, busy, reg_out, carry_flag_out, overflow_flag_out,
         zero_flag_out} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got ready=%b valid=%b busy=%b r=%h C=%b V=%b Z=%b want all 0",
               start_ready, res_valid, busy, reg_out, carry_flag_out, overflow_flag_out,
               zero_flag_out);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({start_ready, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL mid_reset_recover: got ready=%b busy=%b want 1 0", start_ready, busy);
    end
  endtask

  task automatic test_random();
    logic [1:0]    o;
    logic [AW-1:0] a;
    logic [W-1:0]  r;
    logic          c;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(3));
      a = AW'($urandom_range(15));
      r = W'($urandom);
      c = 1'($urandom_range(1));
      run_req($sformatf("rand%0d_op%0d_a%0d_r%h", i, o, a, r), o, a, r, c, model(o, a, r, c));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_shl();
    test_ror();
    test_shr_sat();
    test_shl_overflow();
    test_rotate_sat();
    test_handshake();
    test_reset_mid_run();
    test_random();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
